// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared helpers for the single- and dual-clock FIFOs.
//   clog2     - ceiling log2, used to size pointers and the occupancy count
//   cfg_ok    - legality check for depth (power of two, >=2) and thresholds
//   RDATA_RST - reset/idle value replicated across every rdata bit
package sync_fifo_pkg;

   function automatic int clog2(input int n);
      int r;
      for (r = 0; (1 << r) < n; r++) begin
      end
      return r;
   endfunction

   function automatic bit cfg_ok(input int fd, input int af, input int ae);
      return fd >= 2 && (fd & (fd - 1)) == 0 && af >= 1 && af <= fd && ae >= 0 && ae < fd;
   endfunction

   localparam logic RDATA_RST = 1'b0;

endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: handshake and status bundle between a FIFO and its user.
//   master - producer/consumer side: drives wr, rd, wdata; observes data and flags
//   slave  - FIFO side: samples wr, rd, wdata; drives rdata, flags, count, pulses
interface sync_fifo_param_if #(
   parameter int FW = 8,
   parameter int FD = 8
);
   import sync_fifo_pkg::*;
   localparam int AW = clog2(FD);
   logic          wr;
   logic          rd;
   logic [FW-1:0] wdata;
   logic [FW-1:0] rdata;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;
   modport master (
      output wr, rd, wdata,
      input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
   modport slave (
      input  wr, rd, wdata,
      output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: FD x FW register array, one write port, one read port.
//   clk, rst_n         - clock and async active-low reset (registered read only)
//   we, waddr, wdata   - write port, stored on the rising edge when we is high
//   re, raddr, rdata   - read port
// Macro SYNC_FIFO_FWFT_EN: defined -> combinational read of mem[raddr];
// undefined -> rdata is a register loaded from mem[raddr] when re is high.
module fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int FW = 8,
   parameter int FD = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [FW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [FW-1:0] rdata
);
   // Storage is deliberately left out of reset.
   logic [FW-1:0] mem_q [FD];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign rdata = mem_q[raddr];
`else
   logic [FW-1:0] rdata_q, rdata_d;

   always_comb rdata_d = re ? mem_q[raddr] : rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= {FW{RDATA_RST}};
      else        rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;
`endif
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with occupancy count,
// almost-full/almost-empty thresholds and one-cycle overflow/underflow pulses.
//   clk   - clock, all state on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - sync_fifo_param_if.slave: wr/rd/wdata in; rdata, full, empty,
//           almost_full, almost_empty, count, overflow, underflow out
// Macro SYNC_FIFO_FWFT_EN: defined -> first-word fall-through (rdata shows
// the head whenever not empty, 0 when empty); undefined -> registered read.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int FW    = 8,
   parameter int FD    = 8,
   parameter int AF_TH = FD - 2,
   parameter int AE_TH = 1
) (
   input logic             clk,
   input logic             rst_n,
   sync_fifo_param_if.slave bus
);
   localparam int AW = clog2(FD);
   localparam logic [AW:0] AF_V = (AW + 1)'(AF_TH);
   localparam logic [AW:0] AE_V = (AW + 1)'(AE_TH);

   if (!cfg_ok(FD, AF_TH, AE_TH)) begin : g_cfg_err
      $error("sync_fifo_param: illegal FD/AF_TH/AE_TH");
   end

   logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
   logic          full_q, full_d, empty_q, empty_d;
   logic          af_q, af_d, ae_q, ae_d, ovf_q, ovf_d, unf_q, unf_d;
   logic          wr_ok, rd_ok;
   logic [FW-1:0] mem_rdata;

   // A write into a full FIFO is still accepted when a read frees a slot in
   // the same cycle; pointers carry one extra bit so full and empty differ
   // only in the MSB.
   always_comb begin
      rd_ok   = bus.rd & ~empty_q;
      wr_ok   = bus.wr & (~full_q | rd_ok);
      wptr_d  = wptr_q + {{AW{1'b0}}, wr_ok};
      rptr_d  = rptr_q + {{AW{1'b0}}, rd_ok};
      count_d = wptr_d - rptr_d;
      empty_d = wptr_d == rptr_d;
      full_d  = (wptr_d ^ rptr_d) == {1'b1, {AW{1'b0}}};
      af_d    = count_d >= AF_V;
      ae_d    = count_d <= AE_V;
      ovf_d   = bus.wr & ~wr_ok;
      unf_d   = bus.rd & ~rd_ok;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         af_q    <= 1'b0;
         ae_q    <= 1'b1;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         af_q    <= af_d;
         ae_q    <= ae_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   fifo_mem #(.FW(FW), .FD(FD), .AW(AW)) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_ok),
      .waddr (wptr_q[AW-1:0]),
      .wdata (bus.wdata),
      .re    (rd_ok),
      .raddr (rptr_q[AW-1:0]),
      .rdata (mem_rdata)
   );

`ifdef SYNC_FIFO_FWFT_EN
   assign bus.rdata = empty_q ? {FW{RDATA_RST}} : mem_rdata;
`else
   assign bus.rdata = mem_rdata;
`endif
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = af_q;
   assign bus.almost_empty = ae_q;
   assign bus.count        = count_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed bench for sync_fifo_param (FD=8, FW=8, AF_TH=6, AE_TH=1).
// Builds in either read mode; SYNC_FIFO_FWFT_EN selects the expected rdata.
module tb_sync_fifo_param;
`ifdef SYNC_FIFO_FWFT_EN
   localparam bit FWFT = 1'b1;
`else
   localparam bit FWFT = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   sync_fifo_param_if #(.FW(8), .FD(8)) bus ();

   sync_fifo_param #(.FW(8), .FD(8), .AF_TH(6), .AE_TH(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else n_pass++;
   endtask

   // Drive one cycle of requests, then sample 1 time unit after the edge.
   task automatic cyc(input logic w, input logic r, input logic [7:0] d);
      bus.wr    = w;
      bus.rd    = r;
      bus.wdata = d;
      @(posedge clk);
      #1;
      bus.wr = 1'b0;
      bus.rd = 1'b0;
   endtask

   // Registered mode shows the word just popped; FWFT shows the new head.
   function automatic logic [7:0] rexp(input logic [7:0] cur, input logic [7:0] nxt);
      return FWFT ? nxt : cur;
   endfunction

   initial begin
      logic [7:0] v [8];
      bus.wr = 1'b0;
      bus.rd = 1'b0;
      bus.wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_empty", bus.empty, 1);
      chk("rst_count", bus.count, 0);
      chk("rst_full", bus.full, 0);
      chk("rst_af", bus.almost_full, 0);
      chk("rst_ae", bus.almost_empty, 1);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_ovf", bus.overflow, 0);
      chk("rst_unf", bus.underflow, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         cyc(1, 0, 8'(i));
         chk("fill_count", bus.count, i + 1);
         chk("fill_af", bus.almost_full, (i + 1) >= 6);
         chk("fill_ae", bus.almost_empty, (i + 1) <= 1);
         chk("fill_full", bus.full, i == 7);
         chk("fill_empty", bus.empty, 0);
      end
      cyc(1, 0, 8'hFF);
      chk("ovf_pulse", bus.overflow, 1);
      chk("ovf_count", bus.count, 8);
      cyc(1, 0, 8'hFE);
      chk("ovf_b2b", bus.overflow, 1);
      cyc(0, 0, 8'h00);
      chk("ovf_clear", bus.overflow, 0);
      chk("ovf_full", bus.full, 1);

      for (int i = 0; i < 8; i++) begin
         cyc(0, 1, 8'h00);
         chk("drain_rdata", bus.rdata, rexp(8'(i), i < 7 ? 8'(i + 1) : 8'h00));
         chk("drain_count", bus.count, 7 - i);
         chk("drain_empty", bus.empty, i == 7);
      end
      cyc(0, 1, 8'h00);
      chk("unf_pulse", bus.underflow, 1);
      chk("unf_rdata", bus.rdata, rexp(8'h07, 8'h00));
      cyc(0, 0, 8'h00);
      chk("unf_clear", bus.underflow, 0);

      cyc(1, 1, 8'h42);
      chk("we_unf", bus.underflow, 1);
      chk("we_count", bus.count, 1);
      chk("we_rdata", bus.rdata, rexp(8'h07, 8'h42));
      for (int i = 0; i < 7; i++) cyc(1, 0, 8'(8'h43 + i));
      chk("refill_full", bus.full, 1);
      cyc(1, 1, 8'h50);
      chk("wrf_count", bus.count, 8);
      chk("wrf_ovf", bus.overflow, 0);
      chk("wrf_full", bus.full, 1);
      chk("wrf_rdata", bus.rdata, rexp(8'h42, 8'h43));
      for (int k = 0; k < 7; k++) v[k] = 8'(8'h43 + k);
      v[7] = 8'h50;
      for (int k = 0; k < 8; k++) begin
         cyc(0, 1, 8'h00);
         chk("wrf_order", bus.rdata, rexp(v[k], k < 7 ? v[k + 1] : 8'h00));
      end
      chk("wrf_empty", bus.empty, 1);

      for (int i = 0; i < 3; i++) cyc(1, 0, 8'(8'h60 + i));
      chk("wrap_pre", bus.count, 3);
      for (int i = 0; i < 20; i++) begin
         cyc(1, 1, 8'(8'h63 + i));
         chk("wrap_rdata", bus.rdata, rexp(8'(8'h60 + i), 8'(8'h61 + i)));
         chk("wrap_count", bus.count, 3);
      end

      cyc(1, 0, 8'h77);
      cyc(1, 0, 8'h78);
      chk("mid_count", bus.count, 5);
      rst_n = 1'b0;
      #1;
      chk("mid_empty", bus.empty, 1);
      chk("mid_count0", bus.count, 0);
      chk("mid_rdata", bus.rdata, 0);
      chk("mid_full", bus.full, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1, 0, 8'hA5);
      chk("post_empty", bus.empty, 0);
      chk("post_fall", bus.rdata, rexp(8'h00, 8'hA5));
      cyc(0, 1, 8'h00);
      chk("post_rdata", bus.rdata, rexp(8'hA5, 8'h00));
      chk("post_empty2", bus.empty, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
